// File: rtl/loader_pkg.sv
// Shared types and constants for the boot loader controller and its word assembler.
package loader_pkg;

   typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, RUN, ERR} loader_state_t;

   localparam int unsigned HDR_BYTES      = 4;
   localparam int unsigned BYTES_PER_WORD = 4;

   // States in which the byte stream is being consumed.
   function automatic logic is_loading(input loader_state_t s);
      return (s == HDR) || (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler; word_valid pulses combinationally with the 4th byte
// and word presents the completed word in that same cycle.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q;
   logic [23:0] shift_q;

   assign word       = {byte_data, shift_q};
   assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (clear) begin
         cnt_q   <= '0;
      end else if (byte_valid) begin
         cnt_q   <= cnt_q + 2'd1;
         shift_q <= {byte_data, shift_q[23:8]};
      end
   end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: receives a word-count header plus data words, writes them into imem and then
// releases processor reset. Optional trailing XOR checksum enabled by LOADER_CHECKSUM_EN.
module boot_loader_ctrl
   import loader_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 64,
   parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // One extra bit so a full-memory load (N == IMEM_DEPTH) terminates without wrapping.
   localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t POST_LOAD = CHK;
`else
   localparam loader_state_t POST_LOAD = RUN;
`endif

   loader_state_t     state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_d;
   logic [ADDR_W-1:0] waddr_d;
   logic [31:0]       wdata_d;
   logic              cpu_rst_d, done_d, err_d;

   logic              accept, asm_valid, restart;
   logic [31:0]       word;
   logic              word_valid;

   assign rx_ready  = (state_q == IDLE) || is_loading(state_q);
   assign busy      = is_loading(state_q);
   assign accept    = rx_valid && rx_ready;
   assign asm_valid = accept && (state_q != CHK);
   assign restart   = reload && ((state_q == RUN) || (state_q == ERR));

   word_assembler u_word_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (restart),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (restart) begin
         csum_d = '0;
      end else if (asm_valid) begin
         csum_d = csum_q ^ rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      waddr_d = imem_waddr;
      wdata_d = imem_wdata;
      case (state_q)
         IDLE: begin
            if (accept) state_d = HDR;
         end
         HDR: begin
            if (word_valid) begin
               if (word == 32'd0) begin
                  state_d = POST_LOAD;
               end else if (word > IMEM_DEPTH) begin
                  state_d = ERR;
               end else begin
                  n_d     = word[CNT_W-1:0];
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (word_valid) begin
               we_d    = 1'b1;
               waddr_d = cnt_q[ADDR_W-1:0];
               wdata_d = word;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_d == n_q) state_d = POST_LOAD;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (accept) state_d = (rx_data == csum_q) ? RUN : ERR;
         end
`endif
         RUN, ERR: begin
            if (reload) begin
               state_d = IDLE;
               n_d     = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status follows the state one cycle late, but drops immediately on reload.
      done_d    = (state_q == RUN) && (state_d == RUN);
      err_d     = (state_q == ERR) && (state_d == ERR);
      cpu_rst_d = !done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         imem_we    <= we_d;
         imem_waddr <= waddr_d;
         imem_wdata <= wdata_d;
         cpu_rst    <= cpu_rst_d;
         done       <= done_d;
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Table-driven bench for boot_loader_ctrl; follows LOADER_CHECKSUM_EN when defined.
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        reload;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   boot_loader_ctrl #(.IMEM_DEPTH(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rl;
      logic [43:0] exp;   // {rx_ready, imem_we, waddr, wdata, cpu_rst, busy, done, err}
   } vec_t;

   vec_t        tbl[$];
   int          passed = 0;
   int          total  = 0;
   logic [5:0]  cur_wa = '0;
   logic [31:0] cur_wd = '0;

   localparam logic [43:0] RESET_EXP = {1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};

   task automatic push(input logic v, input logic [7:0] d, input logic rl, input logic rdy,
                       input logic we, input logic crst, input logic bsy, input logic dn,
                       input logic er);
      vec_t x;
      x.v   = v;
      x.d   = d;
      x.rl  = rl;
      x.exp = {rdy, we, cur_wa, cur_wd, crst, bsy, dn, er};
      tbl.push_back(x);
   endtask

   task automatic check(input string name, input logic [43:0] exp);
      logic [43:0] act;
      act = {rx_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, busy, done, err};
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         rx_valid = tbl[i].v;
         rx_data  = tbl[i].d;
         reload   = tbl[i].rl;
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d]", name, i), tbl[i].exp);
      end
      tbl.delete();
      rx_valid = 1'b0;
      rx_data  = '0;
      reload   = 1'b0;
   endtask

   // Header byte not completing the word, while idle/collecting.
   task automatic hdr_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      push(1, b0, 0, 1, 0, 1, 1, 0, 0);
      push(1, b1, 0, 1, 0, 1, 1, 0, 0);
      push(1, b2, 0, 1, 0, 1, 1, 0, 0);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      reload   = 1'b0;
      #12;
      check("reset", RESET_EXP);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_release", RESET_EXP);

      // Two-word load; reload in DATA is ignored.
      hdr_bytes(8'h02, 8'h00, 8'h00);
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h78, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h56, 1, 1, 0, 1, 1, 0, 0);
      push(1, 8'h34, 0, 1, 0, 1, 1, 0, 0);
      cur_wa = 6'd0; cur_wd = 32'h1234_5678;
      push(1, 8'h12, 0, 1, 1, 1, 1, 0, 0);
      push(1, 8'hEF, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hBE, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hAD, 0, 1, 0, 1, 1, 0, 0);
      cur_wa = 6'd1; cur_wd = 32'hDEAD_BEEF;
`ifdef LOADER_CHECKSUM_EN
      push(1, 8'hDE, 0, 1, 1, 1, 1, 0, 0);
      push(1, 8'h28, 0, 0, 0, 1, 0, 0, 0);   // 02^78^56^34^12^EF^BE^AD^DE
`else
      push(1, 8'hDE, 0, 0, 1, 1, 0, 0, 0);
`endif
      push(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
      push(1, 8'h55, 0, 0, 0, 0, 0, 1, 0);
      push(0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
      run_table("load2");

      // Oversize header 0x41 -> error; bytes refused; reload clears.
      hdr_bytes(8'h41, 8'h00, 8'h00);
      push(1, 8'h00, 0, 0, 0, 1, 0, 0, 0);
      push(1, 8'hAA, 0, 0, 0, 1, 0, 0, 1);
      push(1, 8'hAB, 0, 0, 0, 1, 0, 0, 1);
      push(0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
      // Count with nonzero top byte must also be rejected.
      hdr_bytes(8'h01, 8'h00, 8'h00);
      push(1, 8'h01, 0, 0, 0, 1, 0, 0, 0);
      push(0, 8'h00, 0, 0, 0, 1, 0, 0, 1);
      push(0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
      run_table("err");

      // Empty image: straight to run, no writes; stream held valid but refused.
      hdr_bytes(8'h00, 8'h00, 8'h00);
`ifdef LOADER_CHECKSUM_EN
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h00, 0, 0, 0, 1, 0, 0, 0);
`else
      push(1, 8'h00, 0, 0, 0, 1, 0, 0, 0);
`endif
      push(1, 8'hAA, 0, 0, 0, 0, 0, 1, 0);
      push(1, 8'hBB, 0, 0, 0, 0, 0, 1, 0);
      push(0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
      // Full-memory count is accepted and first word lands at address 0.
      hdr_bytes(8'h40, 8'h00, 8'h00);
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h01, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h02, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h03, 0, 1, 0, 1, 1, 0, 0);
      cur_wa = 6'd0; cur_wd = 32'h0403_0201;
      push(1, 8'h04, 0, 1, 1, 1, 1, 0, 0);
      push(0, 8'h00, 1, 1, 0, 1, 1, 0, 0);
      run_table("n0_full");

      // Asynchronous reset mid-load, checked before the next clock edge.
      #2 rst = 1'b1;
      #1 check("rst_async_full", RESET_EXP);
      @(posedge clk);
      #1 rst = 1'b0;
      cur_wa = '0; cur_wd = '0;

      hdr_bytes(8'h01, 8'h00, 8'h00);
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h11, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'h22, 0, 1, 0, 1, 1, 0, 0);
      run_table("mid_pre");
      #2 rst = 1'b1;
      #1 check("rst_mid", RESET_EXP);
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_mid_hold", RESET_EXP);

      hdr_bytes(8'h01, 8'h00, 8'h00);
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hEF, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hBE, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hAD, 0, 1, 0, 1, 1, 0, 0);
      cur_wa = 6'd0; cur_wd = 32'hDEAD_BEEF;
`ifdef LOADER_CHECKSUM_EN
      push(1, 8'hDE, 0, 1, 1, 1, 1, 0, 0);
      push(1, 8'h24, 0, 0, 0, 1, 0, 0, 0);   // wrong: 01^EF^BE^AD^DE is 0x23
      push(0, 8'h00, 0, 0, 0, 1, 0, 0, 1);
      push(0, 8'h00, 1, 1, 0, 1, 0, 0, 0);
      hdr_bytes(8'h01, 8'h00, 8'h00);
      push(1, 8'h00, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hEF, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hBE, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hAD, 0, 1, 0, 1, 1, 0, 0);
      push(1, 8'hDE, 0, 1, 1, 1, 1, 0, 0);
      push(1, 8'h23, 0, 0, 0, 1, 0, 0, 0);
`else
      push(1, 8'hDE, 0, 0, 1, 1, 0, 0, 0);
`endif
      push(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
      run_table("after_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
